// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and stall controller for the 5-stage MIPS core.
//
// Resolves load-use hazards (1-cycle stall), taken branches / jumps (flush)
// and a fixed-latency multiply/divide unit (MD) sequenced by a small FSM and
// a down-counter.
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   mem_read_idex      instruction in EX is a load
//   rt_idex            destination rt of the instruction in EX
//   rs_ifid, rt_ifid   source fields of the instruction in ID
//   branch_taken_ex    branch resolved taken in EX
//   jump_id            jump decoded in ID
//   md_op_idex         instruction in EX is a mul/div
//   pc_write           PC enable
//   if_id_write        IF/ID enable (0 = hold)
//   if_id_flush        IF/ID loads a NOP
//   control_mux        ID/EX enable (0 = all-zero bubble)
//   md_start           one-cycle pulse, MD unit latches operands
//   md_busy            MD occupancy in progress
//   md_done            one-cycle pulse in the final MD_BUSY cycle
//   stall_cnt          saturating count of cycles with pc_write = 0
//                      (only when HAZARD_STALL_CNT_EN is defined)
//
// Build option: define HAZARD_STALL_CNT_EN to add the stall_cnt port/counter.
//
// state   | meaning
// --------+---------------------------------------------------------------
// RUN     | normal issue; branch/jump/load-use handling, MD issue
// MD_BUSY | MD unit occupied; pipeline frozen, bubbles into ID/EX

module hazard_ctrl #(
  parameter int MD_CYCLES = 8,
  parameter int CW        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_read_idex,
  input  logic [4:0] rt_idex,
  input  logic [4:0] rs_ifid,
  input  logic [4:0] rt_ifid,
  input  logic       branch_taken_ex,
  input  logic       jump_id,
  input  logic       md_op_idex,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       if_id_flush,
  output logic       control_mux,
  output logic       md_start,
  output logic       md_busy,
  output logic       md_done
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [0:0]    RUN     = 1'b0;
  localparam logic [0:0]    MD_BUSY = 1'b1;
  localparam logic [CW-1:0] MD_LOAD = CW'(MD_CYCLES - 1);

  logic [0:0]    state, state_nxt;
  logic [CW-1:0] md_cnt, md_cnt_nxt;
  logic          md_done_nxt;
  logic          load_use;

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  assign load_use = mem_read_idex && (rt_idex != 5'd0) &&
                    ((rt_idex == rs_ifid) || (rt_idex == rt_ifid));

  always_comb begin
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    control_mux = 1'b0;
    md_start    = 1'b0;
    md_busy     = 1'b0;
    md_done_nxt = 1'b0;
    state_nxt   = state;
    md_cnt_nxt  = md_cnt;
    // All enables are forced low while reset is held, not just after it.
    if (!rst) begin
      case (state)
        RUN: begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
          control_mux = 1'b1;
          if (branch_taken_ex) begin
            if_id_flush = 1'b1;
            control_mux = 1'b0;
          end else begin
            // MD issue lets the current cycle proceed; load-use/jump still apply.
            if (md_op_idex) begin
              md_start   = 1'b1;
              state_nxt  = MD_BUSY;
              md_cnt_nxt = MD_LOAD;
            end
            if (load_use) begin
              pc_write    = 1'b0;
              if_id_write = 1'b0;
              control_mux = 1'b0;
            end else if (jump_id) begin
              if_id_flush = 1'b1;
            end
          end
        end
        MD_BUSY: begin
          md_busy = 1'b1;
          // md_done is registered, so it is armed one cycle before md_cnt hits 0.
          md_done_nxt = (md_cnt == CW'(1));
          if (md_cnt == '0) begin
            state_nxt  = RUN;
            md_cnt_nxt = '0;
          end else begin
            md_cnt_nxt = md_cnt - CW'(1);
          end
        end
        default: begin
          state_nxt  = RUN;
          md_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      md_cnt  <= '0;
      md_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      md_cnt  <= md_cnt_nxt;
      md_done <= md_done_nxt;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!pc_write && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int MD_CYCLES = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_read_idex;
  logic [4:0] rt_idex, rs_ifid, rt_ifid;
  logic       branch_taken_ex, jump_id, md_op_idex;
  logic       pc_write, if_id_write, if_id_flush, control_mux;
  logic       md_start, md_busy, md_done;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  hazard_ctrl #(.MD_CYCLES(MD_CYCLES), .CW(8)) dut (
    .clk(clk), .rst(rst),
    .mem_read_idex(mem_read_idex), .rt_idex(rt_idex),
    .rs_ifid(rs_ifid), .rt_ifid(rt_ifid),
    .branch_taken_ex(branch_taken_ex), .jump_id(jump_id),
    .md_op_idex(md_op_idex),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .control_mux(control_mux),
    .md_start(md_start), .md_busy(md_busy), .md_done(md_done)
`ifdef HAZARD_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // bit order: pc_write, if_id_write, if_id_flush, control_mux, md_start, md_busy, md_done
  logic [6:0] outs;
  assign outs = {pc_write, if_id_write, if_id_flush, control_mux, md_start, md_busy, md_done};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: number of MD occupancy cycles still to come, and stall total.
  int     md_left = 0;
  longint stall_model = 0;
  logic [6:0] last_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] model_out();
    logic pc, ifw, fl, cm, st, bz, dn;
    logic lu;
    {pc, ifw, fl, cm, st, bz, dn} = 7'b0;
    lu = mem_read_idex && rt_idex != 0 && (rt_idex == rs_ifid || rt_idex == rt_ifid);
    if (rst) begin
      // all zero
    end else if (md_left > 0) begin
      bz = 1'b1;
      dn = (md_left == 1);
    end else if (branch_taken_ex) begin
      pc = 1'b1; ifw = 1'b1; fl = 1'b1;
    end else begin
      pc = !lu; ifw = !lu; cm = !lu;
      fl = !lu && jump_id;
      st = md_op_idex;
    end
    return {pc, ifw, fl, cm, st, bz, dn};
  endfunction

  // Called just after a rising edge with inputs already applied.
  task automatic step(input string tag);
    logic [6:0] exp;
    @(negedge clk);
    exp = model_out();
    last_out = outs;
    chk(tag, {25'd0, outs}, {25'd0, exp});
`ifdef HAZARD_STALL_CNT_EN
    chk({tag, "_stall"}, stall_cnt, stall_model[31:0]);
`endif
    @(posedge clk);
    if (rst) begin
      md_left = 0;
      stall_model = 0;
    end else begin
      if (!exp[6] && stall_model < 64'hFFFF_FFFF) stall_model++;
      if (md_left > 0) md_left--;
      else if (!branch_taken_ex && md_op_idex) md_left = MD_CYCLES;
    end
    #1;
  endtask

  task automatic idle_inputs();
    mem_read_idex = 0; rt_idex = 0; rs_ifid = 0; rt_ifid = 0;
    branch_taken_ex = 0; jump_id = 0; md_op_idex = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #1;
    chk("reset_outs", {25'd0, outs}, 32'd0);
    step("reset_hold");
    step("reset_hold");
    rst = 1'b0;
    step("idle");
    chk("idle_pc_write", {31'd0, last_out[6]}, 32'd1);

    // load-use with rt_idex = 5 matching rs
    mem_read_idex = 1; rt_idex = 5; rs_ifid = 5; rt_ifid = 2;
    step("load_use");
    chk("lu_pc_write", {31'd0, last_out[6]}, 32'd0);
    chk("lu_ctrl_mux", {31'd0, last_out[3]}, 32'd0);
    idle_inputs();
    step("lu_after");
    chk("lu_one_cycle", {31'd0, last_out[6]}, 32'd1);

    // rt_idex = 0 never stalls
    mem_read_idex = 1; rt_idex = 0; rs_ifid = 0; rt_ifid = 0;
    step("lu_r0");
    chk("lu_r0_pc_write", {31'd0, last_out[6]}, 32'd1);

    // branch beats load-use
    mem_read_idex = 1; rt_idex = 7; rs_ifid = 1; rt_ifid = 7; branch_taken_ex = 1;
    step("branch_lu");
    chk("br_flush", {31'd0, last_out[4]}, 32'd1);
    chk("br_ctrl_mux", {31'd0, last_out[3]}, 32'd0);
    chk("br_pc_write", {31'd0, last_out[6]}, 32'd1);

    // jump, no hazard
    idle_inputs(); jump_id = 1;
    step("jump");
    chk("jmp_flush", {31'd0, last_out[4]}, 32'd1);
    chk("jmp_ctrl_mux", {31'd0, last_out[3]}, 32'd1);
    idle_inputs();
    step("jump_after");

    // MD sequence, with branch + load-use presented while busy
    md_op_idex = 1;
    step("md_start");
    chk("md_start_pulse", {31'd0, last_out[2]}, 32'd1);
    md_op_idex = 0;
    for (int i = 1; i <= MD_CYCLES; i++) begin
      if (i == 3 || i == 4) begin
        branch_taken_ex = 1; mem_read_idex = 1; rt_idex = 4; rs_ifid = 4; jump_id = 1;
      end else begin
        idle_inputs();
      end
      step($sformatf("md_t%0d", i));
      chk($sformatf("md_busy_t%0d", i), {31'd0, last_out[1]}, 32'd1);
      chk($sformatf("md_done_t%0d", i), {31'd0, last_out[0]}, (i == MD_CYCLES) ? 32'd1 : 32'd0);
      chk($sformatf("md_flush_t%0d", i), {31'd0, last_out[4]}, 32'd0);
    end
    idle_inputs();
    step("md_resume");
    chk("md_resume_pc", {31'd0, last_out[6]}, 32'd1);
`ifdef HAZARD_STALL_CNT_EN
    chk("md_stall_total", stall_cnt, 32'd9); // 8 MD cycles + 1 earlier load-use
`endif

    // back-to-back MD then async reset at T+3
    md_op_idex = 1;
    step("md2_start");
    md_op_idex = 0;
    step("md2_t1");
    step("md2_t2");
    rst = 1'b1;
    #1;
    chk("rst_async_outs", {25'd0, outs}, 32'd0);
    step("md2_rst");
    rst = 1'b0;
    step("post_rst");
    chk("post_rst_pc", {31'd0, last_out[6]}, 32'd1);
    chk("post_rst_busy", {31'd0, last_out[1]}, 32'd0);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      rst             = ($urandom_range(0, 79) == 0);
      mem_read_idex   = $urandom_range(0, 1);
      rt_idex         = 5'($urandom_range(0, 3));
      rs_ifid         = 5'($urandom_range(0, 3));
      rt_ifid         = 5'($urandom_range(0, 3));
      branch_taken_ex = ($urandom_range(0, 7) == 0);
      jump_id         = ($urandom_range(0, 5) == 0);
      md_op_idex      = ($urandom_range(0, 9) == 0);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
